// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle for the limb-serial wide ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int LIMB_W = 8,
    parameter int LIMBS  = 4
);
    localparam int W = LIMB_W * LIMBS;

    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         N;
    logic         Z;
    logic         C;
    logic         V;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, N, Z, C, V
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, N, Z, C, V
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Wide ALU evaluated one limb per cycle, LSB limb first, with
//                carry chained between limbs; NZCV flags on the last limb.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int LIMB_W = 8,
    parameter int LIMBS  = 4
) (
    input  wire          clk,
    input  wire          rst,
    alu_seq_if.slave     bus
);
    localparam int W     = LIMB_W * LIMBS;
    localparam int CNT_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(LIMBS - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_not = 3'b010;
    localparam logic [2:0] c_op_and = 3'b011;
    localparam logic [2:0] c_op_or  = 3'b100;
    localparam logic [2:0] c_op_xor = 3'b101;
    localparam logic [2:0] c_op_lt  = 3'b110;
    localparam logic [2:0] c_op_eq  = 3'b111;

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_eq;
    logic [W-1:0]     r_res;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;

    logic              w_inv;
    logic              w_last;
    logic [LIMB_W-1:0] w_a_limb;
    logic [LIMB_W-1:0] w_b_limb;
    logic [LIMB_W-1:0] w_b_eff;
    logic [LIMB_W:0]   w_sum;
    logic [LIMB_W-1:0] w_limb_val;
    logic [W-1:0]      w_res_limb;
    logic              w_eq_next;
    logic              w_sub_v;
    logic              w_lt;
    logic [W-1:0]      w_res_final;
    logic              w_is_arith;

    assign w_inv      = (r_op == c_op_sub) || (r_op == c_op_lt);
    assign w_is_arith = (r_op == c_op_add) || (r_op == c_op_sub);
    assign w_last     = (r_cnt == c_last);
    assign w_a_limb   = r_a[r_cnt*LIMB_W +: LIMB_W];
    assign w_b_limb   = r_b[r_cnt*LIMB_W +: LIMB_W];
    assign w_b_eff    = w_inv ? ~w_b_limb : w_b_limb;
    assign w_sum      = {1'b0, w_a_limb} + {1'b0, w_b_eff} + {{LIMB_W{1'b0}}, r_carry};
    assign w_eq_next  = r_eq & (w_a_limb == w_b_limb);

    always_comb begin
        w_limb_val = w_sum[LIMB_W-1:0];
        case (r_op)
            c_op_not: w_limb_val = ~w_a_limb;
            c_op_and: w_limb_val = w_a_limb & w_b_limb;
            c_op_or:  w_limb_val = w_a_limb | w_b_limb;
            c_op_xor: w_limb_val = w_a_limb ^ w_b_limb;
            default:  w_limb_val = w_sum[LIMB_W-1:0];
        endcase
    end

    always_comb begin
        w_res_limb = r_res;
        w_res_limb[r_cnt*LIMB_W +: LIMB_W] = w_limb_val;
    end

    // On the last limb the operand MSBs are the sign bits of the full word.
    assign w_sub_v = (w_a_limb[LIMB_W-1] == w_b_eff[LIMB_W-1]) &&
                     (w_res_limb[W-1] != w_a_limb[LIMB_W-1]);
    assign w_lt    = w_res_limb[W-1] ^ w_sub_v;

    always_comb begin
        w_res_final = w_res_limb;
        if (r_op == c_op_lt) begin
            w_res_final = {W{w_lt}};
        end else if (r_op == c_op_eq) begin
            w_res_final = {W{w_eq_next}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 3'b000;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_eq        <= 1'b0;
            r_res       <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_op       <= bus.op;
                        r_cnt      <= '0;
                        r_carry    <= (bus.op == c_op_sub) || (bus.op == c_op_lt);
                        r_eq       <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_carry <= w_sum[LIMB_W];
                    r_eq    <= w_eq_next;
                    if (w_last) begin
                        r_res       <= w_res_final;
                        r_n         <= w_res_final[W-1];
                        r_z         <= (w_res_final == '0);
                        r_c         <= w_is_arith & w_sum[LIMB_W];
                        r_v         <= w_is_arith & w_sub_v;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end else begin
                        r_res <= w_res_limb;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res       = r_res;
    assign bus.N         = r_n;
    assign bus.Z         = r_z;
    assign bus.C         = r_c;
    assign bus.V         = r_v;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq with a word-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int LIMB_W = 8;
    localparam int LIMBS  = 4;
    localparam int W      = LIMB_W * LIMBS;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    alu_seq_if #(.LIMB_W(LIMB_W), .LIMBS(LIMBS)) bus ();

    alu_seq #(.LIMB_W(LIMB_W), .LIMBS(LIMBS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: returns {N,Z,C,V,res}.
    function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b010: r = ~a;
            3'b011: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: r = ($signed(a) < $signed(b)) ? {W{1'b1}} : '0;
            default: r = (a == b) ? {W{1'b1}} : '0;
        endcase
        return {r[W-1], (r == '0), c, v, r};
    endfunction

    function automatic logic [3:0] nzcv();
        return {bus.N, bus.Z, bus.C, bus.V};
    endfunction

    task automatic run_txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input logic [3:0] exp_f,
                           input int hold);
        @(negedge clk);
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= LIMBS; k++) begin
            chk("out_valid_early", bus.out_valid, 0);
            chk("in_ready_busy", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        chk("out_valid_latency", bus.out_valid, 1);
        chk("in_ready_done", bus.in_ready, 0);
        chk("res", bus.res, exp_res);
        chk("nzcv", nzcv(), exp_f);
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.op = 3'b000; bus.a = $urandom; bus.b = $urandom;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk("hold_res", bus.res, exp_res);
                chk("hold_nzcv", nzcv(), exp_f);
                chk("hold_out_valid", bus.out_valid, 1);
                chk("hold_in_ready", bus.in_ready, 0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("out_valid_cleared", bus.out_valid, 0);
        chk("in_ready_idle", bus.in_ready, 1);
        chk("idle_res_kept", bus.res, exp_res);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   f;
    } vec_t;

    vec_t dir[$];
    logic [W-1:0] corners[5];

    initial begin
        logic [W+3:0] m;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        n_assert = 0; n_fail = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 3'b000; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_nzcv", nzcv(), 0);
        rst = 1'b0;

        dir.push_back('{3'b000, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 4'b0000});
        dir.push_back('{3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011});
        dir.push_back('{3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000});
        dir.push_back('{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110});
        dir.push_back('{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001});
        dir.push_back('{3'b110, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000});
        dir.push_back('{3'b110, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 4'b0100});
        dir.push_back('{3'b111, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 4'b1000});
        dir.push_back('{3'b111, 32'h1234_5678, 32'h1234_5679, 32'h0000_0000, 4'b0100});
        dir.push_back('{3'b010, 32'h0F0F_0F0F, 32'h0000_0000, 32'hF0F0_F0F0, 4'b1000});
        dir.push_back('{3'b011, 32'hF0F0_FFFF, 32'h0FF0_F00F, 32'h00F0_F00F, 4'b0000});
        dir.push_back('{3'b100, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100});
        dir.push_back('{3'b101, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b1000});
        foreach (dir[i]) run_txn(dir[i].op, dir[i].a, dir[i].b, dir[i].res, dir[i].f, 0);

        // Backpressure: result held for 10 cycles with a competing request present.
        run_txn(3'b001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1000, 10);
        run_txn(3'b000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 4'b0000, 0);

        // Reset while the third limb is in progress.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'b000;
        bus.a = 32'h1111_1111; bus.b = 32'h2222_2222;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst_out_valid", bus.out_valid, 0);
        chk("midrun_rst_in_ready", bus.in_ready, 1);
        chk("midrun_rst_res", bus.res, 0);
        chk("midrun_rst_nzcv", nzcv(), 0);
        run_txn(3'b000, 32'h1, 32'h1, 32'h2, 4'b0000, 0);

        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h8000_0000;
        for (int t = 0; t < 60; t++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            if (op == 3'b111 && $urandom_range(0, 1) == 1) b = a;
            m = model(op, a, b);
            run_txn(op, a, b, m[W-1:0], m[W+3:W], (t % 15 == 7) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
